// File: rtl/pipe_chain.sv
// pipe_chain: a linear chain of STAGES valid/data registers with a
// combinational ready chain, per-stage flush, a registered occupancy count,
// and a saturating count of flushed items.
module pipe_chain #(
  parameter int DATA_W = 32,
  parameter int STAGES = 4,
  parameter int CNT_W  = 16,
  localparam int OCC_W = $clog2(STAGES + 1)
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] in_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_data,
  input  logic [STAGES-1:0] flush,
  output logic [OCC_W-1:0]  occupancy,
  output logic [CNT_W-1:0]  flush_cnt
);

  // Wide enough to hold flush_cnt plus one cycle's worth of flushed items,
  // so an overflow shows up as a non-zero upper slice.
  localparam int SUM_W = CNT_W + OCC_W;
  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  logic [STAGES-1:0] r_v;
  logic [DATA_W-1:0] r_d [STAGES];
  logic [OCC_W-1:0]  r_occ;
  logic [CNT_W-1:0]  r_flush_cnt;

  logic [STAGES-1:0] w_rdy;
  logic [STAGES-1:0] w_vin;
  logic [DATA_W-1:0] w_din [STAGES];
  logic [STAGES-1:0] w_v_next;
  logic [STAGES-1:0] w_kill;
  logic [OCC_W-1:0]  w_occ_next;
  logic [OCC_W-1:0]  w_kill_cnt;
  logic [SUM_W-1:0]  w_cnt_sum;
  logic [CNT_W-1:0]  w_cnt_next;

  // A stage can accept when it is empty, its item is being killed, or its
  // item can itself move on; the last stage looks at the downstream ready.
  assign w_rdy[STAGES-1] = ~r_v[STAGES-1] | flush[STAGES-1] | out_ready;

  // Only items that are actually present count as flushed.
  assign w_kill = flush & r_v;

  genvar gi;
  generate
    for (gi = 0; gi < STAGES - 1; gi++) begin : g_rdy
      assign w_rdy[gi] = ~r_v[gi] | flush[gi] | w_rdy[gi+1];
    end

    for (gi = 0; gi < STAGES; gi++) begin : g_stage
      if (gi == 0) begin : g_head
        assign w_vin[gi] = in_valid;
        assign w_din[gi] = in_data;
      end else begin : g_body
        // A flushed item in the previous stage arrives here as a bubble.
        assign w_vin[gi] = r_v[gi-1] & ~flush[gi-1];
        assign w_din[gi] = r_d[gi-1];
      end

      assign w_v_next[gi] = w_rdy[gi] ? w_vin[gi] : r_v[gi];

      // Data register: loads only when a valid item moves in, otherwise holds.
      always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
          r_d[gi] <= '0;
        end else if (w_rdy[gi] && w_vin[gi]) begin
          r_d[gi] <= w_din[gi];
        end
      end
    end
  endgenerate

  // Population count of next-cycle valid bits and of items killed this cycle.
  always_comb begin
    w_occ_next = '0;
    w_kill_cnt = '0;
    for (int k = 0; k < STAGES; k++) begin
      w_occ_next = w_occ_next + OCC_W'(w_v_next[k]);
      w_kill_cnt = w_kill_cnt + OCC_W'(w_kill[k]);
    end
  end

  // Saturating add of the flushed-item count.
  always_comb begin
    w_cnt_sum  = {{OCC_W{1'b0}}, r_flush_cnt} + SUM_W'(w_kill_cnt);
    w_cnt_next = w_cnt_sum[CNT_W-1:0];
    if (w_cnt_sum[SUM_W-1:CNT_W] != '0) begin
      w_cnt_next = CNT_MAX;
    end
  end

  // Valid bits, occupancy and flush counter state.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_v         <= '0;
      r_occ       <= '0;
      r_flush_cnt <= '0;
    end else begin
      r_v         <= w_v_next;
      r_occ       <= w_occ_next;
      r_flush_cnt <= w_cnt_next;
    end
  end

  assign in_ready  = w_rdy[0];
  assign out_valid = r_v[STAGES-1] & ~flush[STAGES-1];
  assign out_data  = r_d[STAGES-1];
  assign occupancy = r_occ;
  assign flush_cnt = r_flush_cnt;

endmodule

// File: tb/tb_pipe_chain.sv
// Directed bench for pipe_chain: a 4-stage instance and a 1-stage instance
// with a 2-bit flush counter, checked against per-instance scoreboards.
module tb_pipe_chain;

  logic clk;
  logic rst_n;

  // 4-stage, 32-bit, 16-bit counter instance
  logic        a_in_valid;
  logic        a_in_ready;
  logic [31:0] a_in_data;
  logic        a_out_valid;
  logic        a_out_ready;
  logic [31:0] a_out_data;
  logic [3:0]  a_flush;
  logic [2:0]  a_occ;
  logic [15:0] a_fcnt;

  // 1-stage, 8-bit, 2-bit counter instance
  logic        b_in_valid;
  logic        b_in_ready;
  logic [7:0]  b_in_data;
  logic        b_out_valid;
  logic        b_out_ready;
  logic [7:0]  b_out_data;
  logic [0:0]  b_flush;
  logic [0:0]  b_occ;
  logic [1:0]  b_fcnt;

  logic [31:0] qa[$];
  logic [7:0]  qb[$];
  int a_pushes;
  int a_pops;
  int checks;
  int errors;

  pipe_chain #(.DATA_W(32), .STAGES(4), .CNT_W(16)) u_a (
    .clk       (clk),
    .reset     (rst_n),
    .in_valid  (a_in_valid),
    .in_ready  (a_in_ready),
    .in_data   (a_in_data),
    .out_valid (a_out_valid),
    .out_ready (a_out_ready),
    .out_data  (a_out_data),
    .flush     (a_flush),
    .occupancy (a_occ),
    .flush_cnt (a_fcnt)
  );

  pipe_chain #(.DATA_W(8), .STAGES(1), .CNT_W(2)) u_b (
    .clk       (clk),
    .reset     (rst_n),
    .in_valid  (b_in_valid),
    .in_ready  (b_in_ready),
    .in_data   (b_in_data),
    .out_valid (b_out_valid),
    .out_ready (b_out_ready),
    .out_data  (b_out_data),
    .flush     (b_flush),
    .occupancy (b_occ),
    .flush_cnt (b_fcnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  // One clock: handshakes sampled on the falling edge, then return 1 time
  // unit after the rising edge.
  task automatic cycle();
    logic [31:0] ea;
    logic [7:0]  eb;
    @(negedge clk);
    if (a_in_valid && a_in_ready) begin
      qa.push_back(a_in_data);
      a_pushes++;
    end
    if (a_out_valid && a_out_ready) begin
      a_pops++;
      chk("a_out_expected", 64'(qa.size() != 0), 64'd1);
      if (qa.size() != 0) begin
        ea = qa.pop_front();
        $display("A out 0x%0h (expect 0x%0h)", a_out_data, ea);
        chk("a_out_data", 64'(a_out_data), 64'(ea));
      end
    end
    if (b_in_valid && b_in_ready) qb.push_back(b_in_data);
    if (b_out_valid && b_out_ready) begin
      chk("b_out_expected", 64'(qb.size() != 0), 64'd1);
      if (qb.size() != 0) begin
        eb = qb.pop_front();
        $display("B out 0x%0h (expect 0x%0h)", b_out_data, eb);
        chk("b_out_data", 64'(b_out_data), 64'(eb));
      end
    end
    @(posedge clk);
    #1;
  endtask

  task automatic send_a(input logic [31:0] val);
    int n0;
    n0 = a_pushes;
    a_in_valid = 1'b1;
    a_in_data  = val;
    for (int t = 0; t < 20; t++) begin
      cycle();
      if (a_pushes != n0) break;
    end
    a_in_valid = 1'b0;
    chk("a_send_accepted", 64'(a_pushes - n0), 64'd1);
  endtask

  task automatic drain_a();
    for (int t = 0; t < 30 && qa.size() != 0; t++) cycle();
    chk("a_drained", 64'(qa.size()), 64'd0);
  endtask

  initial begin
    int p0;
    checks = 0; errors = 0; a_pushes = 0; a_pops = 0;
    rst_n = 1'b0;
    a_in_valid = 1'b0; a_in_data = '0; a_out_ready = 1'b0; a_flush = '0;
    b_in_valid = 1'b0; b_in_data = '0; b_out_ready = 1'b0; b_flush = '0;

    // Reset state
    #2;
    chk("rst_out_valid", 64'(a_out_valid), 64'd0);
    chk("rst_out_data",  64'(a_out_data),  64'd0);
    chk("rst_occ",       64'(a_occ),       64'd0);
    chk("rst_fcnt",      64'(a_fcnt),      64'd0);
    chk("rst_in_ready",  64'(a_in_ready),  64'd1);
    chk("rst_b_in_ready", 64'(b_in_ready), 64'd1);
    @(posedge clk); #1;
    chk("rst_hold_occ", 64'(a_occ), 64'd0);
    rst_n = 1'b1;

    // Flush on an empty chain is ignored
    a_flush = 4'hF;
    cycle();
    a_flush = 4'h0;
    chk("empty_flush_fcnt", 64'(a_fcnt), 64'd0);

    // Streaming 1..8 with out_ready held high
    a_out_ready = 1'b1;
    for (int i = 0; i < 8; i++) begin
      a_in_valid = 1'b1;
      a_in_data  = 32'(i + 1);
      #1;
      chk("stream_in_ready",  64'(a_in_ready),  64'd1);
      chk("stream_out_valid", 64'(a_out_valid), 64'(i >= 4));
      chk("stream_occ",       64'(a_occ),       64'((i < 4) ? i : 4));
      cycle();
    end
    a_in_valid = 1'b0;
    for (int j = 0; j < 4; j++) begin
      chk("stream_tail_valid", 64'(a_out_valid), 64'd1);
      chk("stream_tail_occ",   64'(a_occ),       64'(4 - j));
      cycle();
    end
    chk("stream_end_valid", 64'(a_out_valid), 64'd0);
    chk("stream_q_empty",   64'(qa.size()),   64'd0);

    // Backpressure: only four of six offers fit
    a_out_ready = 1'b0;
    p0 = a_pops;
    for (int i = 0; i < 4; i++) send_a(32'hA + 32'(i));
    chk("bp_in_ready", 64'(a_in_ready),  64'd0);
    chk("bp_occ",      64'(a_occ),       64'd4);
    chk("bp_valid",    64'(a_out_valid), 64'd1);
    a_in_valid = 1'b1;
    a_in_data  = 32'hE;
    begin
      int n0;
      n0 = a_pushes;
      repeat (3) cycle();
      chk("bp_no_accept", 64'(a_pushes - n0), 64'd0);
    end
    a_out_ready = 1'b1;
    send_a(32'hE);
    send_a(32'hF);
    drain_a();
    chk("bp_pop_count", 64'(a_pops - p0), 64'd6);

    // Mid-chain flush of stage 1 (holding C)
    a_out_ready = 1'b0;
    p0 = a_pops;
    for (int i = 0; i < 4; i++) send_a(32'hA + 32'(i));
    a_flush = 4'b0010;
    cycle();
    a_flush = 4'b0000;
    for (int k = 0; k < qa.size(); k++) begin
      if (qa[k] == 32'hC) begin
        qa.delete(k);
        break;
      end
    end
    chk("mid_fcnt",     64'(a_fcnt),     64'd1);
    chk("mid_occ",      64'(a_occ),      64'd3);
    chk("mid_in_ready", 64'(a_in_ready), 64'd1);
    a_out_ready = 1'b1;
    drain_a();
    chk("mid_pop_count", 64'(a_pops - p0), 64'd3);

    // Flush of the output stage while downstream is ready
    a_out_ready = 1'b0;
    send_a(32'h77);
    repeat (3) cycle();
    chk("oflush_pre_valid", 64'(a_out_valid), 64'd1);
    a_out_ready = 1'b1;
    a_flush = 4'b1000;
    #1;
    chk("oflush_valid", 64'(a_out_valid), 64'd0);
    cycle();
    a_flush = 4'b0000;
    chk("oflush_q_size", 64'(qa.size()), 64'd1);
    if (qa.size() != 0) qa.delete(0);
    chk("oflush_fcnt",   64'(a_fcnt),      64'd2);
    chk("oflush_occ",    64'(a_occ),       64'd0);
    chk("oflush_after",  64'(a_out_valid), 64'd0);

    // Asynchronous reset with a full chain, between clock edges
    a_out_ready = 1'b0;
    for (int i = 0; i < 4; i++) send_a(32'h31 + 32'(i));
    chk("ar_full_occ", 64'(a_occ), 64'd4);
    #2;
    rst_n = 1'b0;
    #1;
    chk("ar_out_valid", 64'(a_out_valid), 64'd0);
    chk("ar_occ",       64'(a_occ),       64'd0);
    chk("ar_fcnt",      64'(a_fcnt),      64'd0);
    chk("ar_in_ready",  64'(a_in_ready),  64'd1);
    chk("ar_out_data",  64'(a_out_data),  64'd0);
    qa.delete();
    rst_n = 1'b1;
    a_out_ready = 1'b1;
    send_a(32'h99);
    for (int k = 0; k < 3; k++) begin
      chk("ar_latency_wait", 64'(a_out_valid), 64'd0);
      cycle();
    end
    chk("ar_latency_out", 64'(a_out_valid), 64'd1);
    cycle();
    chk("ar_q_empty", 64'(qa.size()), 64'd0);

    // Single-stage instance: pass-through with 1-cycle latency
    b_out_ready = 1'b1;
    b_in_valid  = 1'b1;
    b_in_data   = 8'h55;
    #1;
    chk("b_in_ready_empty", 64'(b_in_ready), 64'd1);
    cycle();
    b_in_valid = 1'b0;
    chk("b_lat_valid", 64'(b_out_valid), 64'd1);
    chk("b_lat_data",  64'(b_out_data),  64'h55);
    chk("b_lat_occ",   64'(b_occ),       64'd1);
    cycle();
    chk("b_after_valid", 64'(b_out_valid), 64'd0);

    // Single-stage ready = out_ready | ~v
    b_out_ready = 1'b0;
    b_in_valid  = 1'b1;
    b_in_data   = 8'h11;
    cycle();
    b_in_valid = 1'b0;
    #1;
    chk("b_rdy_full_blocked", 64'(b_in_ready), 64'd0);
    b_out_ready = 1'b1;
    #1;
    chk("b_rdy_full_open", 64'(b_in_ready), 64'd1);
    b_out_ready = 1'b0;
    #1;
    chk("b_rdy_full_again", 64'(b_in_ready), 64'd0);

    // Saturation: five flushed items on a 2-bit counter
    for (int i = 0; i < 5; i++) begin
      b_flush    = 1'b1;
      b_in_valid = 1'b1;
      b_in_data  = 8'h20 + 8'(i);
      cycle();
      chk("b_sat_fcnt", 64'(b_fcnt), 64'((i + 1 > 3) ? 3 : i + 1));
    end
    b_flush    = 1'b0;
    b_in_valid = 1'b0;
    repeat (5) if (qb.size() != 0) void'(qb.pop_front());
    chk("b_sat_q_size", 64'(qb.size()), 64'd1);
    b_out_ready = 1'b1;
    for (int t = 0; t < 10 && qb.size() != 0; t++) cycle();
    chk("b_drained",    64'(qb.size()), 64'd0);
    chk("b_final_fcnt", 64'(b_fcnt),    64'd3);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/pipe_chain.md
PIPE_CHAIN -- requirements
Module: pipe_chain

Interface
REQ-001 SHALL provide parameter DATA_W, default 32, meaning payload width in bits (legal 1..64).
REQ-002 SHALL provide parameter STAGES, default 4, meaning number of register stages (legal 1..8).
REQ-003 SHALL provide parameter CNT_W, default 16, meaning width of the flush counter.
REQ-004 SHALL provide port clk  input  1  rising-edge clock; the block uses one clock only.
REQ-005 SHALL provide port reset  input  1  reset, asynchronous and active-low.
REQ-006 SHALL provide port in_valid  input  1  upstream offers in_data.
REQ-007 SHALL provide port in_ready  output  1  block accepts in_data this cycle.
REQ-008 SHALL provide port in_data  input  DATA_W  upstream payload.
REQ-009 SHALL provide port out_valid  output  1  out_data is valid.
REQ-010 SHALL provide port out_ready  input  1  downstream accepts out_data.
REQ-011 SHALL provide port out_data  output  DATA_W  payload from stage STAGES-1.
REQ-012 SHALL provide port flush  input  STAGES  bit k kills the item held in stage k.
REQ-013 SHALL provide port occupancy  output  clog2(STAGES+1)  number of valid stages.
REQ-014 SHALL provide port flush_cnt  output  CNT_W  count of flushed valid items.

Function
REQ-015 SHALL hold per stage k (0 = input end) a valid bit v[k] and a data register d[k].
REQ-016 SHALL compute ready chain combinationally: rdy[STAGES-1] = ~v[last] | flush[last] | out_ready; rdy[k] = ~v[k] | flush[k] | rdy[k+1].
REQ-017 SHALL drive in_ready = rdy[0], independent of in_valid.
REQ-018 SHALL drive out_valid = v[last] & ~flush[last] and out_data = d[last].
REQ-019 SHALL treat an output transfer as out_valid & out_ready; an input transfer as in_valid & in_ready.
REQ-020 SHALL, on each edge where rdy[k] = 1, load stage k from stage k-1 (or from in_valid/in_data for k = 0): v[k] <= v[k-1] & ~flush[k-1] (v[-1] = in_valid).
REQ-021 SHALL, on each edge where rdy[k] = 1 and the incoming valid is 1, load d[k]; d[k] SHALL otherwise hold its value.
REQ-022 SHALL hold v[k] and d[k] unchanged when rdy[k] = 0.
REQ-023 SHALL apply flush[k] to the item in stage k at the start of the cycle; a flushed item never reaches stage k+1 or the output.
REQ-024 SHALL ignore flush[k] when v[k] = 0.
REQ-025 SHALL give latency STAGES cycles from input transfer to out_valid on an empty chain with out_ready = 1, and throughput one item per cycle.
REQ-026 SHALL preserve order; no item SHALL be duplicated or lost except by flush.
REQ-027 SHALL drive occupancy as the registered population count of v[].
REQ-028 SHALL increment flush_cnt by the number of bits with flush[k] & v[k] each edge, saturating at 2^CNT_W-1.
REQ-029 SHALL tolerate multiple flush bits, an input transfer, and an output transfer in the same cycle, each applied per REQ-020..REQ-028.

Reset
REQ-030 SHALL, while reset = 0, asynchronously clear all v[k], d[k], occupancy and flush_cnt to 0, giving out_valid = 0 and out_data = 0.
REQ-031 SHALL, while reset = 0, drive in_ready = 1, since all stages are empty.
REQ-032 SHALL discard any in-flight items on a reset mid-operation, and the first edge after release SHALL behave as for an empty chain.

Verification
REQ-033 SHALL pass the streaming test: STAGES=4, out_ready = 1, in_data 0x1..0x8 on consecutive cycles -> out_data 0x1..0x8 on consecutive cycles, first out_valid 4 cycles after the first accept, occupancy steady at 4.
REQ-034 SHALL pass the backpressure test: out_ready = 0, offer 0xA,0xB,0xC,0xD,0xE,0xF -> 4 accepted, in_ready = 0 after the 4th, occupancy = 4; then out_ready = 1 -> outputs 0xA..0xF in order, none duplicated.
REQ-035 SHALL pass the mid-chain flush test: chain holds stage3..0 = A,B,C,D, out_ready = 0, flush = 4'b0010 for one cycle -> C dropped, D moves to stage 1, flush_cnt = 1; drain -> outputs A,B,D.
REQ-036 SHALL pass the output flush test: v[3] = 1, flush = 4'b1000, out_ready = 1 -> out_valid = 0 that cycle, item removed, flush_cnt increments by 1.
REQ-037 SHALL pass the asynchronous reset test: reset pulsed low between clock edges with chain full -> out_valid, occupancy and flush_cnt go to 0 without a clock edge, and in_ready goes to 1.
REQ-038 SHALL pass the single-stage and saturation test: STAGES=1 passes 0x55 with 1-cycle latency and in_ready = out_ready | ~v[0]; with CNT_W=2 and 5 flushed items, flush_cnt = 3.
